// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: NOP encoding and fetch FSM state codes.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [0:0] ST_FETCH   = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

endpackage

// File: rtl/fetch_queue_fq_storage.sv
// Entry storage for the fetch queue: DEPTH registers of {instruction, pc}, one write and one read port.
module fq_storage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [2*XLEN-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [2*XLEN-1:0] rdata
);

  logic [2*XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential reads, buffers returned instructions for decode,
// and restarts on redirect, discarding any stale in-flight response.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int         PTR_W    = $clog2(DEPTH),
  localparam int         CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [XLEN-1:0]  i_address,
  output logic             i_read,
  input  logic [XLEN-1:0]  i_instruction,
  input  logic             i_busywait,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [XLEN-1:0]  d_instruction,
  output logic [XLEN-1:0]  d_pc,
  output logic [XLEN-1:0]  d_pc_4,
  output logic [CNT_W-1:0] count
);

  logic [0:0]        state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   target;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [2*XLEN-1:0] head;
  logic              complete;
  logic              push;
  logic              pop;

  // DISCARD keeps the stale request asserted until memory finishes it.
  assign i_read    = (state == ST_DISCARD) || (count < CNT_W'(DEPTH));
  assign i_address = fetch_pc;
  assign complete  = i_read && !i_busywait;
  assign push      = (state == ST_FETCH) && complete && !redirect;
  assign pop       = d_valid && d_ready && !redirect;

  fq_storage #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({i_instruction, fetch_pc}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH;
      fetch_pc <= RESET_PC;
      target   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      target <= redirect_pc;
      // A still-busy access must finish at its original address before we restart.
      if (i_read && i_busywait) begin
        state <= ST_DISCARD;
      end else begin
        state    <= ST_FETCH;
        fetch_pc <= redirect_pc;
      end
    end else begin
      if (state == ST_DISCARD && complete) begin
        state    <= ST_FETCH;
        fetch_pc <= target;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign d_valid       = (count != '0);
  assign d_instruction = d_valid ? head[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
  assign d_pc          = d_valid ? head[XLEN-1:0] : '0;
  assign d_pc_4        = d_pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a zero-latency memory returning addr+0x100.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read;
  logic [31:0] i_instruction;
  logic        i_busywait;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_instruction;
  logic [31:0] d_pc;
  logic [31:0] d_pc_4;
  logic [2:0]  count;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_instruction (i_instruction),
    .i_busywait    (i_busywait),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .d_valid       (d_valid),
    .d_ready       (d_ready),
    .d_instruction (d_instruction),
    .d_pc          (d_pc),
    .d_pc_4        (d_pc_4),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_instruction = i_address + 32'h100;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdir, input logic [31:0] rpc,
                               input logic busy, input logic rdy);
    redirect    = rdir;
    redirect_pc = rpc;
    i_busywait  = busy;
    d_ready     = rdy;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    i_busywait  = 1'b0;
    d_ready     = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state, first read issued immediately at RESET_PC
    checkOutput("rst_count",  32'(count), 32'd0);
    checkOutput("rst_dvalid", 32'(d_valid), 32'd0);
    checkOutput("rst_dinstr", d_instruction, 32'h13);
    checkOutput("rst_dpc",    d_pc, 32'h0);
    checkOutput("rst_iread",  32'(i_read), 32'd1);
    checkOutput("rst_iaddr",  i_address, 32'h0);

    // Fill with zero-wait memory and no decode
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("fill_count", 32'(count), 32'(k));
      if (k < 4) begin
        checkOutput("fill_iaddr", i_address, 32'(4 * k));
        checkOutput("fill_iread", 32'(i_read), 32'd1);
      end
    end
    checkOutput("full_iread",  32'(i_read), 32'd0);
    checkOutput("full_dvalid", 32'(d_valid), 32'd1);
    checkOutput("full_dinstr", d_instruction, 32'h100);
    checkOutput("full_dpc",    d_pc, 32'h0);
    checkOutput("full_dpc4",   d_pc_4, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("full_hold_count", 32'(count), 32'd4);

    // Single pop from a full queue
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("pop_count",  32'(count), 32'd3);
    checkOutput("pop_dpc",    d_pc, 32'h4);
    checkOutput("pop_dinstr", d_instruction, 32'h104);
    checkOutput("pop_iread",  32'(i_read), 32'd1);
    checkOutput("pop_iaddr",  i_address, 32'h10);

    // Pop while the fetch is busy: address held, no push
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("busypop_count", 32'(count), 32'd2);
    checkOutput("busypop_dpc",   d_pc, 32'h8);
    checkOutput("busypop_iaddr", i_address, 32'h10);

    // Redirect at COUNT=2 with the access completing this cycle
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    checkOutput("redir_count",  32'(count), 32'd0);
    checkOutput("redir_dvalid", 32'(d_valid), 32'd0);
    checkOutput("redir_iaddr",  i_address, 32'h40);
    checkOutput("redir_dinstr", d_instruction, 32'h13);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("redir_first_dpc",    d_pc, 32'h40);
    checkOutput("redir_first_dinstr", d_instruction, 32'h140);
    checkOutput("redir_first_dpc4",   d_pc_4, 32'h44);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("redir_count2", 32'(count), 32'd2);
    checkOutput("redir_iaddr2", i_address, 32'h48);

    // Simultaneous push and pop across pointer wrap
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("pp_count", 32'(count), 32'd2);
      checkOutput("pp_dpc",   d_pc, 32'h40 + 32'(4 * i));
    end

    // Busy fetch at 0x8 for three cycles, empty-queue pops ignored
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
    checkOutput("r8_iaddr", i_address, 32'h8);
    checkOutput("r8_count", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("busy_iaddr",  i_address, 32'h8);
      checkOutput("busy_iread",  32'(i_read), 32'd1);
      checkOutput("busy_count",  32'(count), 32'd0);
      checkOutput("busy_dvalid", 32'(d_valid), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("busydone_count",  32'(count), 32'd1);
    checkOutput("busydone_dpc",    d_pc, 32'h8);
    checkOutput("busydone_dinstr", d_instruction, 32'h108);
    checkOutput("busydone_iaddr",  i_address, 32'hC);

    // Redirect during a busy fetch of 0xC, retargeted while discarding
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("pend_iaddr", i_address, 32'hC);
    applyStimulus(1'b1, 32'h60, 1'b1, 1'b0);
    checkOutput("disc_count", 32'(count), 32'd0);
    checkOutput("disc_iaddr", i_address, 32'hC);
    checkOutput("disc_iread", 32'(i_read), 32'd1);
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b0);
    checkOutput("disc2_iaddr", i_address, 32'hC);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("discdone_count",  32'(count), 32'd0);
    checkOutput("discdone_dvalid", 32'(d_valid), 32'd0);
    checkOutput("discdone_iaddr",  i_address, 32'h80);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("after_disc_count",  32'(count), 32'd1);
    checkOutput("after_disc_dpc",    d_pc, 32'h80);
    checkOutput("after_disc_dinstr", d_instruction, 32'h180);

    // Reset overrides a simultaneous redirect and completing access
    reset = 1'b1;
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
    reset    = 1'b0;
    redirect = 1'b0;
    d_ready  = 1'b0;
    checkOutput("rst2_count", 32'(count), 32'd0);
    checkOutput("rst2_iaddr", i_address, 32'h0);
    checkOutput("rst2_iread", 32'(i_read), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst2_first_dpc",    d_pc, 32'h0);
    checkOutput("rst2_first_dinstr", d_instruction, 32'h100);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, instruction and address width in bits.
REQ-002 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2 to 16.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 I_ADDRESS  output  XLEN  instruction memory read address.
REQ-007 I_READ  output  1  instruction memory read request.
REQ-008 I_INSTRUCTION  input  XLEN  instruction memory read data; valid when I_READ=1 and I_BUSYWAIT=0.
REQ-009 I_BUSYWAIT  input  1  instruction memory busy; an access completes in the first cycle with I_READ=1 and I_BUSYWAIT=0.
REQ-010 REDIRECT  input  1  branch/jump taken: flush the queue and restart fetch.
REQ-011 REDIRECT_PC  input  XLEN  restart address, sampled when REDIRECT=1.
REQ-012 D_VALID  output  1  head entry valid toward decode.
REQ-013 D_READY  input  1  decode accepts the head entry; a pop occurs when D_VALID=1 and D_READY=1.
REQ-014 D_INSTRUCTION  output  XLEN  head instruction.
REQ-015 D_PC  output  XLEN  address of the head instruction.
REQ-016 D_PC_4  output  XLEN  D_PC+4, modulo 2^XLEN.
REQ-017 COUNT  output  clog2(DEPTH)+1  occupied entries, 0 to DEPTH.

Function
REQ-018 Fetch FSM states: FETCH (normal issue) and DISCARD (waiting for a stale access to finish).
REQ-019 In FETCH: I_READ=1 when COUNT<DEPTH at the start of the cycle, otherwise 0; I_ADDRESS=fetch PC.
REQ-020 In FETCH, a completing access SHALL push {I_INSTRUCTION, fetch PC} at the tail and set fetch PC to fetch PC+4.
REQ-021 While I_BUSYWAIT=1, I_ADDRESS and I_READ SHALL remain unchanged.
REQ-022 A pushed entry SHALL appear on the D_* outputs no earlier than the following cycle; there is no fall-through bypass.
REQ-023 D_VALID=1 exactly when COUNT>0; when COUNT=0, D_INSTRUCTION=32'h00000013 (NOP) and D_PC=0.
REQ-024 Push and pop in the same cycle SHALL leave COUNT unchanged; a pop with COUNT=0 is ignored.
REQ-025 At COUNT=DEPTH no new read is issued that cycle, even if a pop also occurs.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 REDIRECT=1 SHALL take priority over push and pop in that cycle: COUNT becomes 0, pointers are zeroed, and REDIRECT_PC is captured.
REQ-028 REDIRECT with no access pending, or with the access completing in that same cycle: discard any response, stay in FETCH, fetch PC=REDIRECT_PC, and issue from the next cycle.
REQ-029 REDIRECT while I_READ=1 and I_BUSYWAIT=1: enter DISCARD and hold the old I_ADDRESS until the access completes.
REQ-030 On completion in DISCARD: drop the response, set fetch PC to the captured target, and return to FETCH.
REQ-031 A new REDIRECT while in DISCARD SHALL overwrite the captured target.
REQ-032 Back-to-back single-cycle accesses SHALL sustain one push per cycle while COUNT<DEPTH.

Reset
REQ-033 While RESET=1 at a rising edge, the block SHALL set:
- state=FETCH;
- fetch PC=RESET_PC;
- pointers=0 and COUNT=0;
- D_VALID=0 and D_INSTRUCTION=NOP;
- captured target=0.
REQ-034 RESET SHALL override REDIRECT and any in-flight access; a response arriving in the reset cycle is dropped.
REQ-035 The first I_READ=1, with I_ADDRESS=RESET_PC, SHALL occur in the first cycle after RESET deasserts.

Structure
REQ-036 The shared package SHALL hold the NOP encoding constant 32'h00000013 and the FSM state encoding for FETCH and DISCARD.
REQ-037 Entry storage SHALL be one sub-module, fq_storage: DEPTH x (2*XLEN) registers with one write port and one read port.
REQ-038 Pointer, COUNT and FSM logic SHALL reside in fetch_queue.

Verification
REQ-039 Reset then zero-wait memory returning addr+0x100, D_READY=0 -> I_ADDRESS 0,4,8,C; COUNT reaches 4; I_READ=0; D_INSTRUCTION=0x100, D_PC=0, D_PC_4=4.
REQ-040 Full queue, D_READY=1 for one cycle -> one pop, D_PC becomes 4, COUNT=3; next cycle I_READ=1 with I_ADDRESS=0x10.
REQ-041 I_BUSYWAIT=1 for 3 cycles on fetch at 0x8 -> I_ADDRESS holds 0x8, COUNT unchanged, then one push on the fourth cycle.
REQ-042 REDIRECT to 0x40 at COUNT=2 with no wait -> next cycle COUNT=0, D_VALID=0, I_ADDRESS=0x40; first popped D_PC=0x40.
REQ-043 REDIRECT to 0x80 during a busy fetch of 0xC -> that response is not enqueued; next issued I_ADDRESS=0x80.
REQ-044 Simultaneous push and pop at COUNT=2 for 10 cycles -> COUNT stays 2 and D_PC increments by 4 per cycle.
